// File: rtl/irq_ctrl_pkg.sv
// Shared definitions for the interrupt controller: register indices, field
// encodings and the CPU-side channel count.
package irq_ctrl_pkg;

  localparam int CPU_IRQ_CH = 8;
  localparam int IRQ_ADDR_W = 3;

  typedef enum logic [IRQ_ADDR_W-1:0] {
    IRQ_ADDR_PENDING  = 3'd0,
    IRQ_ADDR_MODE     = 3'd1,
    IRQ_ADDR_POLARITY = 3'd2,
    IRQ_ADDR_ENABLE   = 3'd3,
    IRQ_ADDR_RAW      = 3'd4,
    IRQ_ADDR_SWSET    = 3'd5
  } irq_addr_e;

  localparam logic IRQ_MODE_LEVEL = 1'b0;
  localparam logic IRQ_MODE_EDGE  = 1'b1;
  localparam logic IRQ_POL_LOW    = 1'b0;
  localparam logic IRQ_POL_HIGH   = 1'b1;

endpackage

// File: rtl/irq_ctrl_if.sv
// Bus-slave register window of the interrupt controller (active-low strobes,
// registered single-cycle ready).
interface irq_ctrl_if #(
  parameter int DATA_W = 32
);
  import irq_ctrl_pkg::*;

  logic                  cs_;
  logic                  as_;
  logic                  rw;
  logic [IRQ_ADDR_W-1:0] addr;
  logic [DATA_W-1:0]     wr_data;
  logic [DATA_W-1:0]     rd_data;
  logic                  rdy_;

  modport master (output cs_, as_, rw, addr, wr_data, input rd_data, rdy_);
  modport slave  (input cs_, as_, rw, addr, wr_data, output rd_data, rdy_);

endinterface

// File: rtl/irq_ctrl_sync_edge.sv
// Per-channel input path: synchronizer chain, polarity correction and a
// previous-sample flop giving a one-cycle rising-edge pulse.
module irq_sync_edge #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic din,
  input  logic pol,
  output logic act,
  output logic rise
);

  logic [SYNC_STAGES-1:0] sync_p0;
  logic                   prev_p1;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync_p0 <= '0;
      prev_p1 <= 1'b0;
    end else begin
      sync_p0 <= {sync_p0[SYNC_STAGES-2:0], din};
      prev_p1 <= act;
    end
  end

  // pol = 1 passes the line through, pol = 0 inverts an active-low source
  assign act  = sync_p0[SYNC_STAGES-1] ^ ~pol;
  assign rise = act & ~prev_p1;

endmodule

// File: rtl/irq_ctrl.sv
// Interrupt controller top: per-channel input paths, pending/mode/polarity/
// enable registers, bus register window and the registered CPU request vector.
module irq_ctrl
  import irq_ctrl_pkg::*;
#(
  parameter int IRQ_CH      = CPU_IRQ_CH,
  parameter int SYNC_STAGES = 2,
  parameter int DATA_W      = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [IRQ_CH-1:0] int_in,
  irq_ctrl_if.slave         bus,
  output logic [IRQ_CH-1:0] irq
);

  logic [IRQ_CH-1:0] pending_q, mode_q, pol_q, enable_q;
  logic [IRQ_CH-1:0] act, rise;
  logic [IRQ_CH-1:0] wr_ch, w1c, swset, pending_d;
  logic [DATA_W-1:0] rd_mux, rd_data_q;
  logic              rdy_q;
  logic              access, wr_acc, rd_acc;
  logic              unused_wr_bits;

  for (genvar g = 0; g < IRQ_CH; g++) begin : g_ch
    irq_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync_edge (
      .clk  (clk),
      .reset(reset),
      .din  (int_in[g]),
      .pol  (pol_q[g]),
      .act  (act[g]),
      .rise (rise[g])
    );
  end

  assign access = ~bus.cs_ & ~bus.as_;
  assign wr_acc = access & ~bus.rw;
  assign rd_acc = access & bus.rw;
  assign wr_ch  = bus.wr_data[IRQ_CH-1:0];
  assign unused_wr_bits = ^bus.wr_data[DATA_W-1:IRQ_CH];

  assign w1c   = (wr_acc && bus.addr == IRQ_ADDR_PENDING) ? wr_ch : '0;
  assign swset = (wr_acc && bus.addr == IRQ_ADDR_SWSET)   ? wr_ch : '0;

  // Edge channels: set/SWSET beat W1C beats hold. Level channels track act.
  assign pending_d = ( mode_q & (rise | swset | (pending_q & ~w1c)))
                   | (~mode_q & (act | swset));

  always_comb begin
    rd_mux = '0;
    case (bus.addr)
      IRQ_ADDR_PENDING:  rd_mux[IRQ_CH-1:0] = pending_q;
      IRQ_ADDR_MODE:     rd_mux[IRQ_CH-1:0] = mode_q;
      IRQ_ADDR_POLARITY: rd_mux[IRQ_CH-1:0] = pol_q;
      IRQ_ADDR_ENABLE:   rd_mux[IRQ_CH-1:0] = enable_q;
      IRQ_ADDR_RAW:      rd_mux[IRQ_CH-1:0] = act;
      default:           rd_mux = '0;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pending_q <= '0;
      mode_q    <= {IRQ_CH{IRQ_MODE_LEVEL}};
      pol_q     <= {IRQ_CH{IRQ_POL_HIGH}};
      enable_q  <= '0;
      irq       <= '0;
      rdy_q     <= 1'b1;
      rd_data_q <= '0;
    end else begin
      pending_q <= pending_d;
      irq       <= pending_q & enable_q;
      rdy_q     <= ~access;
      rd_data_q <= rd_acc ? rd_mux : '0;
      if (wr_acc) begin
        case (bus.addr)
          IRQ_ADDR_MODE:     mode_q   <= wr_ch;
          IRQ_ADDR_POLARITY: pol_q    <= wr_ch;
          IRQ_ADDR_ENABLE:   enable_q <= wr_ch;
          default: ;
        endcase
      end
    end
  end

  assign bus.rdy_    = rdy_q;
  assign bus.rd_data = rd_data_q;

endmodule

// File: tb/tb_irq_ctrl.sv
// Scoreboard bench for irq_ctrl: directed scenarios plus random traffic,
// expected outputs from a cycle-level behavioural model.
module tb_irq_ctrl;
  import irq_ctrl_pkg::*;

  localparam int CH = 8;
  localparam int DW = 32;

  logic          clk = 1'b0;
  logic          reset;
  logic [CH-1:0] int_in;
  logic [CH-1:0] irq;

  irq_ctrl_if #(.DATA_W(DW)) bus ();

  irq_ctrl #(.IRQ_CH(CH), .SYNC_STAGES(2), .DATA_W(DW)) dut (
    .clk   (clk),
    .reset (reset),
    .int_in(int_in),
    .bus   (bus),
    .irq   (irq)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [CH-1:0] irq;
    logic          rdy_;
    logic [DW-1:0] rd;
  } exp_t;

  exp_t expq[$];
  int   vectors = 0;
  int   miscompares = 0;

  // Behavioural model state
  logic [CH-1:0] m_pend, m_mode, m_pol, m_en, m_prev, m_irq;
  logic [CH-1:0] m_line[$];   // raw samples still travelling through the synchronizer

  task automatic model_reset();
    m_pend = '0; m_mode = '0; m_pol = '1; m_en = '0; m_prev = '0; m_irq = '0;
    m_line.delete();
    m_line.push_back('0);
    m_line.push_back('0);
  endtask

  task automatic check(input string name, input logic [DW-1:0] got, input logic [DW-1:0] want);
    vectors++;
    if (got !== want) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", name, got, want);
    end
  endtask

  // One clock: predict outputs from the inputs currently driven, advance the edge.
  task automatic step();
    logic          acc, rd_rw;
    logic [2:0]    a;
    logic [CH-1:0] w, act, rise, pend_n, irq_n, smp;
    logic [DW-1:0] rd;
    acc   = !bus.cs_ && !bus.as_;
    rd_rw = bus.rw;
    a     = bus.addr;
    w     = bus.wr_data[CH-1:0];
    smp   = int_in;
    act   = m_line[0] ^ ~m_pol;
    rise  = act & ~m_prev;
    rd    = '0;
    if (acc && rd_rw) begin
      case (a)
        3'd0: rd[CH-1:0] = m_pend;
        3'd1: rd[CH-1:0] = m_mode;
        3'd2: rd[CH-1:0] = m_pol;
        3'd3: rd[CH-1:0] = m_en;
        3'd4: rd[CH-1:0] = act;
        default: rd = '0;
      endcase
    end
    for (int i = 0; i < CH; i++) begin
      logic sw, clr;
      sw  = acc && !rd_rw && a == 3'd5 && w[i];
      clr = acc && !rd_rw && a == 3'd0 && w[i];
      if (sw || (m_mode[i] ? rise[i] : act[i])) pend_n[i] = 1'b1;
      else if (m_mode[i])                       pend_n[i] = m_pend[i] && !clr;
      else                                      pend_n[i] = 1'b0;
    end
    irq_n = m_pend & m_en;
    @(posedge clk);
    m_pend = pend_n;
    m_irq  = irq_n;
    m_prev = act;
    void'(m_line.pop_front());
    m_line.push_back(smp);
    if (acc && !rd_rw) begin
      if (a == 3'd1) m_mode = w;
      if (a == 3'd2) m_pol  = w;
      if (a == 3'd3) m_en   = w;
    end
    expq.push_back('{irq: m_irq, rdy_: !acc, rd: rd});
    #1;
  endtask

  task automatic bus_idle();
    bus.cs_ = 1'b1; bus.as_ = 1'b1; bus.rw = 1'b1; bus.addr = '0; bus.wr_data = '0;
  endtask

  task automatic idle(input int n);
    bus_idle();
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic wr(input logic [2:0] a, input logic [DW-1:0] d);
    bus.cs_ = 1'b0; bus.as_ = 1'b0; bus.rw = 1'b0; bus.addr = a; bus.wr_data = d;
    step();
  endtask

  task automatic rd(input logic [2:0] a);
    bus.cs_ = 1'b0; bus.as_ = 1'b0; bus.rw = 1'b1; bus.addr = a; bus.wr_data = $urandom;
    step();
  endtask

  // Monitor: compare every presented cycle against the scoreboard head
  always @(negedge clk) begin
    if (expq.size() > 0) begin
      exp_t e;
      e = expq.pop_front();
      vectors++;
      if (irq !== e.irq || bus.rdy_ !== e.rdy_ || bus.rd_data !== e.rd) begin
        miscompares++;
        $display("FAIL cycle_out: irq=%h rdy_=%b rd_data=%h expected irq=%h rdy_=%b rd_data=%h",
                 irq, bus.rdy_, bus.rd_data, e.irq, e.rdy_, e.rd);
      end
    end
  end

  initial begin
    reset  = 1'b1;
    int_in = '0;
    bus_idle();
    model_reset();
    @(posedge clk); @(posedge clk); #1;
    check("reset_irq",  {24'b0, irq}, 32'h0);
    check("reset_rdy",  {31'b0, bus.rdy_}, 32'h1);
    check("reset_rd",   bus.rd_data, 32'h0);
    reset = 1'b0;
    idle(2);

    // Register readback after reset
    for (int i = 0; i < 8; i++) rd(3'(i));
    idle(1);

    // Edge mode, channel 0: one-cycle pulse, then W1C
    wr(3'd1, 32'h01); wr(3'd3, 32'h01); idle(1);
    int_in[0] = 1'b1; idle(1); int_in[0] = 1'b0;
    idle(5);
    wr(3'd0, 32'h01); idle(3);

    // Level mode, channel 3, active-low; W1C while held has no lasting effect
    wr(3'd1, 32'h00); wr(3'd2, 32'hF7); wr(3'd3, 32'h08);
    idle(5);
    wr(3'd0, 32'h08); rd(3'd0); idle(1);
    int_in[3] = 1'b1; idle(5); rd(3'd0);
    wr(3'd2, 32'hFF); idle(1);

    // Edge channel 2: rise lands on the same edge as W1C -> set wins
    wr(3'd1, 32'h04); wr(3'd3, 32'h04); wr(3'd0, 32'hFF); idle(1);
    int_in[2] = 1'b1; idle(2);
    wr(3'd0, 32'h04); rd(3'd0);
    int_in[2] = 1'b0; idle(2);
    wr(3'd0, 32'h04); idle(1);

    // SWSET with the channel disabled, then enable it
    wr(3'd1, 32'h80); wr(3'd3, 32'h00); wr(3'd5, 32'h80); rd(3'd0); rd(3'd5);
    wr(3'd3, 32'h80); idle(2);
    wr(3'd0, 32'h80); idle(2);

    // Back-to-back reads; upper-address writes ignored
    wr(3'd7, 32'hFFFF_FFFF); rd(3'd4); rd(3'd7); idle(1);
    wr(3'd2, 32'hFFFF_FF00); rd(3'd2); rd(3'd4); wr(3'd2, 32'hFF); idle(3);

    // Random traffic
    for (int n = 0; n < 600; n++) begin
      int_in = int_in ^ CH'($urandom & $urandom & $urandom);
      if ($urandom_range(0, 1) == 1) begin
        logic [2:0] a;
        a = 3'($urandom_range(0, 7));
        if ($urandom_range(0, 1) == 1) rd(a);
        else wr(a, $urandom);
      end else begin
        idle(1);
      end
    end
    int_in = '0;
    idle(4);

    // Reset in the middle of a read response
    wr(3'd3, 32'hFF); wr(3'd5, 32'hFF); rd(3'd4); bus_idle();
    @(negedge clk); #1;
    check("mid_rdy_before", {31'b0, bus.rdy_}, 32'h0);
    reset = 1'b1; #1;
    check("mid_rdy_after",  {31'b0, bus.rdy_}, 32'h1);
    check("mid_rd_after",   bus.rd_data, 32'h0);
    check("mid_irq_after",  {24'b0, irq}, 32'h0);
    expq.delete();
    @(posedge clk); #2;
    reset = 1'b0;
    model_reset();
    for (int i = 0; i < 6; i++) rd(3'(i));
    idle(2);

    @(negedge clk); #1;
    check("scoreboard_drained", expq.size(), 32'h0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

endmodule
